muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32: operand/result width; legal values 32, 64.
REQ-002 Parameter MUL_BITS, default 2: multiplier bits retired per cycle; legal values 1, 2, 4, 8 (must divide XLEN).
REQ-003 Parameter DIV_EARLY_OUT, default 1: when 1, divide skips leading-zero dividend bits.
REQ-004 Port: rst  in  1  reset, asynchronous, active-low.
REQ-005 Port: clk  in  1  sole clock, rising edge.
REQ-006 Port: enable  in  1  start request; sampled only in IDLE.
REQ-007 Port: clear  in  1  pipeline kill; aborts the current operation.
REQ-008 Port: op  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-009 Port: rdata1  in  XLEN  operand A (multiplicand/dividend).
REQ-010 Port: rdata2  in  XLEN  operand B (multiplier/divisor).
REQ-011 Port: ready  out  1  result valid, single-cycle pulse.
REQ-012 Port: result  out  XLEN  product or quotient/remainder; valid while ready=1.
REQ-013 Port: busy  out  1  high in any state other than IDLE.

Function
REQ-014 FSM states SHALL be IDLE, MUL, DIV, DONE; only IDLE accepts a request.
REQ-015 IDLE with enable=1, clear=0 SHALL latch op, rdata1 and rdata2, take absolute values for signed operands, record result sign, and move to MUL (op<4) or DIV (op>=4).
REQ-016 MUL SHALL iterate XLEN/MUL_BITS cycles using a 2*XLEN accumulator, then go to DONE.
REQ-017 MUL, MULH, MULHSU and MULHU SHALL return product bits [XLEN-1:0], [2XLEN-1:XLEN], [2XLEN-1:XLEN] and [2XLEN-1:XLEN], respectively.
REQ-018 Signedness: MULH treats both operands as signed; MULHSU treats A as signed and B as unsigned; MULHU and DIVU/REMU treat both as unsigned.
REQ-019 Signed products SHALL be negated as a full 2*XLEN value before upper-half selection.
REQ-020 DIV SHALL run restoring division, one quotient bit per cycle, XLEN cycles, then go to DONE.
REQ-021 With DIV_EARLY_OUT=1, DIV SHALL first shift out leading zeros of |A| in a single cycle, giving XLEN-clz(|A|)+1 cycles in DIV.
REQ-022 Divide by zero SHALL go IDLE->DONE directly, with quotient all-ones and remainder = rdata1.
REQ-023 Signed overflow (A = -2^(XLEN-1), B = -1, DIV/REM) SHALL go IDLE->DONE directly, with quotient = A and remainder 0.
REQ-024 Quotient sign SHALL be sign(A) xor sign(B); remainder sign SHALL be sign(A); both are applied in the DONE transition.
REQ-025 DONE SHALL assert ready=1 with result for exactly one cycle, ignore enable, and return to IDLE.
REQ-026 Latency, counted from the enable cycle to the ready cycle: MUL = XLEN/MUL_BITS+1 cycles; DIV = XLEN+1 cycles (fewer with early-out); special cases = 1 cycle.
REQ-027 clear=1 in any state SHALL force state IDLE on the next edge and mask ready to 0 combinationally in the same cycle.
REQ-028 clear=1 together with enable=1 in IDLE SHALL start nothing.
REQ-029 result SHALL hold its last value outside DONE; it is don't-care to consumers.
REQ-030 enable held high through BUSY and DONE SHALL NOT restart the operation; a new request is taken only in IDLE.
REQ-031 Operand changes while busy SHALL have no effect on the result.

Reset
REQ-032 rst=0 SHALL asynchronously force state IDLE, ready=0, busy=0, result=0, and clear all accumulators and counters.
REQ-033 Reset asserted mid-operation SHALL discard the operation; no ready pulse SHALL follow deassertion.

Verification (XLEN=32, MUL_BITS=2, DIV_EARLY_OUT=0 unless stated)
REQ-034 MULH, A=0xFFFFFFFF, B=0x00000002, enable for 1 cycle -> ready at cycle 17, result=0xFFFFFFFF; MULHU with the same operands -> result=0x00000001.
REQ-035 DIV, A=0xFFFFFFF9 (-7), B=2 -> ready at cycle 33, result=0xFFFFFFFD; REM with the same operands -> result=0xFFFFFFFF.
REQ-036 DIVU, B=0, A=0x1234 -> ready at cycle 1, result=0xFFFFFFFF; REMU -> result=0x1234; DIV A=0x80000000, B=0xFFFFFFFF -> result=0x80000000 at cycle 1.
REQ-037 Start MUL, assert clear at cycle 5 -> ready never asserted, busy=0 from cycle 6; enable at cycle 6 starts a fresh op with correct result.
REQ-038 enable held high continuously across two back-to-back DIVU ops -> exactly one ready pulse per op, the second op starting in the IDLE cycle after DONE.
REQ-039 Randomised ops, all MUL_BITS values and DIV_EARLY_OUT=1, with rst pulsed mid-op -> results match a reference model, with no spurious ready.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2^MUL_BITS shift-add multiplier
// and restoring divider sharing one 2*XLEN accumulator, with an optional leading-zero skip.
module muldiv_unit #(
    parameter int XLEN          = 32,
    parameter int MUL_BITS      = 2,
    parameter int DIV_EARLY_OUT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            clear,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rdata1,
    input  logic [XLEN-1:0] rdata2,
    output logic            ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam int PW = XLEN + MUL_BITS;
    localparam int W2 = 2 * XLEN;
    localparam logic [CW-1:0]   MUL_ITERS = CW'(XLEN / MUL_BITS);
    localparam logic [CW-1:0]   DIV_ITERS = CW'(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic            neg_q, neg_d;
    logic            norm_q, norm_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [W2-1:0]   acc_q, acc_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            sa, sb;
    logic [XLEN-1:0] abs_a, abs_b;
    logic [PW-1:0]   pp, sum;
    logic [XLEN:0]   shifted, diff;
    logic [CW-1:0]   lz;

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [CW-1:0] clz(input logic [XLEN-1:0] v);
        logic [CW-1:0] n;
        n = CW'(XLEN);
        for (int i = 0; i < XLEN; i++)
            if (v[i]) n = CW'(XLEN - 1 - i);
        return n;
    endfunction

    // Sign is applied to the full-width product so the upper half of a negative product is exact.
    function automatic logic [XLEN-1:0] fold_result(input logic [W2-1:0] acc, input logic [2:0] f,
                                                    input logic neg);
        logic [W2-1:0]   prod;
        logic [XLEN-1:0] part;
        prod = neg ? -acc : acc;
        if (!f[2]) begin
            part = (f[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[W2-1:XLEN];
        end else begin
            part = f[1] ? acc[W2-1:XLEN] : acc[XLEN-1:0];
            part = neg_if(part, neg);
        end
        return part;
    endfunction

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        norm_d   = norm_q;
        cnt_d    = cnt_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        result_d = result_q;

        sa      = rdata1[XLEN-1] & (op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6});
        sb      = rdata2[XLEN-1] & (op inside {3'd0, 3'd1, 3'd4, 3'd6});
        abs_a   = neg_if(rdata1, sa);
        abs_b   = neg_if(rdata2, sb);
        pp      = PW'(opb_q) * PW'(acc_q[MUL_BITS-1:0]);
        sum     = PW'(acc_q[W2-1:XLEN]) + pp;
        shifted = acc_q[W2-1:XLEN-1];
        diff    = shifted - {1'b0, opb_q};
        lz      = clz(acc_q[XLEN-1:0]);

        case (state_q)
            S_IDLE: begin
                if (enable && !clear) begin
                    op_d = op;
                    if (!op[2]) begin
                        neg_d   = sa ^ sb;
                        opb_d   = abs_a;
                        acc_d   = {{XLEN{1'b0}}, abs_b};
                        cnt_d   = MUL_ITERS;
                        state_d = S_MUL;
                    end else if (rdata2 == '0) begin
                        result_d = op[1] ? rdata1 : '1;
                        state_d  = S_DONE;
                    end else if (!op[0] && rdata1 == MIN_NEG && rdata2 == '1) begin
                        result_d = op[1] ? '0 : rdata1;
                        state_d  = S_DONE;
                    end else begin
                        neg_d   = op[1] ? sa : (sa ^ sb);
                        opb_d   = abs_b;
                        acc_d   = {{XLEN{1'b0}}, abs_a};
                        cnt_d   = DIV_ITERS;
                        norm_d  = (DIV_EARLY_OUT != 0);
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL: begin
                acc_d = {sum, acc_q[XLEN-1:MUL_BITS]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d = fold_result(acc_d, op_q, neg_q);
                    state_d  = S_DONE;
                end
            end
            S_DIV: begin
                if (norm_q) begin
                    // One-cycle skip of the dividend's leading zeros; those quotient bits are all 0.
                    norm_d = 1'b0;
                    acc_d  = {acc_q[W2-1:XLEN], acc_q[XLEN-1:0] << lz};
                    cnt_d  = DIV_ITERS - lz;
                    if (lz == DIV_ITERS) begin
                        result_d = fold_result(acc_d, op_q, neg_q);
                        state_d  = S_DONE;
                    end
                end else begin
                    if (!diff[XLEN])
                        acc_d = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                    else
                        acc_d = {shifted[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        result_d = fold_result(acc_d, op_q, neg_q);
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (clear) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            norm_q   <= 1'b0;
            cnt_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            norm_q   <= norm_d;
            cnt_q    <= cnt_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign ready  = (state_q == S_DONE) && !clear;
    assign busy   = (state_q != S_IDLE);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and reference-model bench for muldiv_unit: one instance at MUL_BITS=2 without
// early-out and one at MUL_BITS=8 with early-out, both driven by the same inputs.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable, clear;
    logic [2:0]  op;
    logic [31:0] rdata1, rdata2;
    logic        ready1, busy1, ready2, busy2;
    logic [31:0] result1, result2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .MUL_BITS(2), .DIV_EARLY_OUT(0)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear), .op(op),
        .rdata1(rdata1), .rdata2(rdata2), .ready(ready1), .result(result1), .busy(busy1)
    );

    muldiv_unit #(.XLEN(32), .MUL_BITS(8), .DIV_EARLY_OUT(1)) u_dut8 (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear), .op(op),
        .rdata1(rdata1), .rdata2(rdata2), .ready(ready2), .result(result2), .busy(busy2)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl[20];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa_l, sb_l;
        logic [63:0] ua, ub, p;
        logic        ovf;
        sa_l = longint'($signed(a));
        sb_l = longint'($signed(b));
        ua   = {32'b0, a};
        ub   = {32'b0, b};
        ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p    = '0;
        case (o)
            3'd0: begin p = sa_l * sb_l; return p[31:0]; end
            3'd1: begin p = sa_l * sb_l; return p[63:32]; end
            3'd2: begin p = sa_l * ub;   return p[63:32]; end
            3'd3: begin p = ua * ub;     return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                   input int mb, input int early);
        logic [31:0] aa;
        int          z;
        if (!o[2]) return 32 / mb + 1;
        if (b == 0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        if (early == 0) return 33;
        aa = (!o[0] && a[31]) ? -a : a;
        z = 32;
        for (int i = 0; i < 32; i++)
            if (aa[i]) z = 31 - i;
        return 32 - z + 2;
    endfunction

    task automatic scramble();
        op     = 3'($urandom);
        rdata1 = $urandom;
        rdata2 = $urandom;
    endtask

    // Issue one op for a single cycle, scramble operands while busy, watch both units for 40 cycles.
    task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat1);
        int          n1, n2, c1, c2, lat2;
        logic [31:0] r1, r2;
        n1 = 0; n2 = 0; c1 = -1; c2 = -1; r1 = 'x; r2 = 'x;
        lat2 = exp_lat(o, a, b, 8, 1);
        op = o; rdata1 = a; rdata2 = b; enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        scramble();
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (ready1) begin n1++; c1 = c; r1 = result1; end
            if (ready2) begin n2++; c2 = c; r2 = result2; end
            @(posedge clk); #1;
            scramble();
        end
        check({nm, " res1"}, 64'(r1), 64'(exp));
        check({nm, " pulses1"}, 64'(n1), 64'd1);
        check({nm, " lat1"}, 64'(c1), 64'(lat1));
        check({nm, " res8"}, 64'(r2), 64'(exp));
        check({nm, " pulses8"}, 64'(n2), 64'd1);
        check({nm, " lat8"}, 64'(c2), 64'(lat2));
    endtask

    task automatic drain(input string nm);
        logic idle;
        idle = 1'b0;
        for (int c = 0; c < 60 && !idle; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            idle = !busy1 && !busy2;
        end
        check({nm, " drained"}, 64'(idle), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        int          n1, n2, p0, p1;
        logic [31:0] q0, q1;
        logic [2:0]  o;
        logic [31:0] a, b;

        tbl[0]  = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 17};
        tbl[1]  = '{3'd3, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 17};
        tbl[2]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
        tbl[3]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
        tbl[4]  = '{3'd5, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 1};
        tbl[5]  = '{3'd7, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1};
        tbl[6]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        tbl[7]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        tbl[8]  = '{3'd0, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 17};
        tbl[9]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 17};
        tbl[10] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 17};
        tbl[11] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 17};
        tbl[12] = '{3'd5, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 33};
        tbl[13] = '{3'd7, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 33};
        tbl[14] = '{3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
        tbl[15] = '{3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33};
        tbl[16] = '{3'd6, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 1};
        tbl[17] = '{3'd4, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 33};
        tbl[18] = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 17};
        tbl[19] = '{3'd5, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 33};

        rst = 1'b0; enable = 1'b0; clear = 1'b0; op = '0; rdata1 = '0; rdata2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ready1", 64'(ready1), 64'd0);
        check("reset busy1", 64'(busy1), 64'd0);
        check("reset result1", 64'(result1), 64'd0);
        check("reset ready8", 64'(ready2), 64'd0);
        check("reset busy8", 64'(busy2), 64'd0);
        check("reset result8", 64'(result2), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 20; i++)
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat);

        // Clear at cycle 5 of a MUL: the x8 unit is in DONE then, so its ready must be masked.
        op = 3'd0; rdata1 = 32'd3; rdata2 = 32'd5; enable = 1'b1;
        n1 = 0; n2 = 0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            enable = 1'b0;
            if (c == 5) clear = 1'b1;
            @(negedge clk);
            if (ready1) n1++;
            if (ready2) n2++;
            if (c == 5) begin
                check("clear c5 busy1", 64'(busy1), 64'd1);
                check("clear c5 busy8", 64'(busy2), 64'd1);
            end
        end
        check("clear no ready1", 64'(n1), 64'd0);
        check("clear masks ready8", 64'(n2), 64'd0);
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        check("clear c6 busy1", 64'(busy1), 64'd0);
        check("clear c6 busy8", 64'(busy2), 64'd0);
        run_op("post-clear MUL", 3'd0, 32'h0000_1234, 32'h0000_0100, 32'h0012_3400, 17);

        // Clear during a special-case DONE cycle masks ready combinationally.
        op = 3'd5; rdata1 = 32'h1234; rdata2 = 32'h0; enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0; clear = 1'b1;
        @(negedge clk);
        check("done+clear busy1", 64'(busy1), 64'd1);
        check("done+clear ready1", 64'(ready1), 64'd0);
        check("done+clear ready8", 64'(ready2), 64'd0);
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        check("after done+clear busy1", 64'(busy1), 64'd0);

        // clear together with enable in IDLE starts nothing.
        @(posedge clk); #1;
        op = 3'd0; rdata1 = 32'd2; rdata2 = 32'd2; enable = 1'b1; clear = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0; clear = 1'b0;
        @(negedge clk);
        check("clr+en busy1", 64'(busy1), 64'd0);
        check("clr+en busy8", 64'(busy2), 64'd0);
        @(posedge clk); #1;

        // enable held high: back-to-back DIVU, one pulse per op.
        op = 3'd5; rdata1 = 32'd100; rdata2 = 32'd7; enable = 1'b1;
        n1 = 0; p0 = -1; p1 = -1; q0 = 'x; q1 = 'x;
        for (int c = 1; c <= 67; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (ready1) begin
                if (n1 == 0) begin p0 = c; q0 = result1; end
                else begin p1 = c; q1 = result1; end
                n1++;
            end
        end
        enable = 1'b0;
        check("b2b pulses", 64'(n1), 64'd2);
        check("b2b first cycle", 64'(p0), 64'd33);
        check("b2b second cycle", 64'(p1), 64'd67);
        check("b2b first res", 64'(q0), 64'h0E);
        check("b2b second res", 64'(q1), 64'h0E);
        drain("b2b");

        // Asynchronous reset mid-DIV discards the op.
        op = 3'd4; rdata1 = 32'h0000_FFFF; rdata2 = 32'd3; enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async rst busy1", 64'(busy1), 64'd0);
        check("async rst busy8", 64'(busy2), 64'd0);
        check("async rst result1", 64'(result1), 64'd0);
        check("async rst result8", 64'(result2), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        n1 = 0; n2 = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (ready1) n1++;
            if (ready2) n2++;
        end
        check("post-rst no ready1", 64'(n1), 64'd0);
        check("post-rst no ready8", 64'(n2), 64'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 24; i++) begin
            o = 3'(i % 8);
            a = $urandom >> $urandom_range(0, 31);
            b = $urandom >> $urandom_range(0, 28);
            if (i % 5 == 4) b = 32'h0;
            if (i % 7 == 6) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (i % 6 == 1) a = -a;
            run_op($sformatf("rnd%0d op%0d", i, o), o, a, b, ref_model(o, a, b), exp_lat(o, a, b, 2, 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
